clock_mode_sequencer: RTL and testbench
=======================================

Name: clock_mode_sequencer

Overview:
- Top-level controller for the countdown-clock datapath. Owns the global mode (`currentState`) and converts the raw button events into mode transitions, pause control and counter reload pulses.
- Generates the 1 Hz count-enable tick from `clk`, latches and validates the user-set start time, and muxes the BCD display source.
- Sits between the button inputs and the per-state datapath modules (counting, setting).

Parameters:
- TICK_DIV, 50000000: `clk` cycles per count tick; minimum 2.
- DEFAULT_TIME, 16'h0500: BCD mm:ss start value after reset (05:00).

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous, active-low reset
- btn_mode  input  1  mode button, synchronous level
- btn_start  input  1  start/pause button, synchronous level
- btn_clear  input  1  clear button, synchronous level
- set_value  input  16  BCD mm:ss proposed by the setting datapath
- set_valid  input  1  set_value is to be captured this cycle
- count_digits  input  16  BCD display value from the counting datapath
- finished  input  1  counting datapath has reached 00:00 (level)
- currentState  output  3  0=COUNTING, 1=SETTING, 2=EXPIRED
- initialClockValue  output  16  validated start time, BCD
- load  output  1  one-cycle pulse: counting datapath reloads initialClockValue
- tick  output  1  one-cycle count enable
- paused  output  1  counting halted
- alarm  output  1  high while EXPIRED
- digitsOut  output  16  BCD display word {min1,min0,sec1,sec0}

Behaviour:
- Reset (`reset`=0, asynchronous):
  - currentState=SETTING, initialClockValue=DEFAULT_TIME.
  - load=0, tick=0, paused=1, alarm=0, prescaler=0, button edge history=0.
- Buttons:
  - Each button passes through a 2-FF synchronizer and a rising-edge detector; an event is a one-cycle pulse.
  - Button-to-event latency is 3 clk cycles.
  - A held button produces exactly one event.
- Event priority within one cycle: finished > clear > mode > start. Lower-priority events in the same cycle are discarded.
- SETTING:
  - set_valid=1 captures set_value only if it is valid BCD: every nibble <=9 and sec1 <=5. An invalid value is ignored and initialClockValue is held.
  - mode event -> COUNTING: paused=0, load=1 on the first COUNTING cycle.
  - start and clear events are ignored. tick=0.
- COUNTING:
  - finished=1 -> EXPIRED. The finished check is masked in the cycle load is high and the cycle after it.
  - clear event -> stay in COUNTING, load=1 next cycle, paused=1, prescaler=0.
  - mode event -> SETTING, paused=1.
  - start event toggles paused.
- EXPIRED:
  - alarm=1, paused=1.
  - mode or clear event -> SETTING, alarm=0. start event is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 in COUNTING with paused=0.
  - At TICK_DIV-1 it wraps to 0 and asserts tick for exactly 1 cycle.
  - It holds its value while paused, so the tick phase survives a pause/resume.
  - It clears to 0 on every state change and on clear.
  - The first tick after load occurs TICK_DIV cycles after load.
  - Width is $clog2(TICK_DIV).
- digitsOut (registered, 1-cycle latency):
  - SETTING: set_value.
  - COUNTING: count_digits.
  - EXPIRED: 16'h0000.
- load and tick are never high in the same cycle.
- Reset mid-operation forces the reset values immediately; no load pulse is issued on reset release.

Optional Feature:
- Macro: EXPIRED_BLINK_EN.
- Defined:
  - In EXPIRED the prescaler free-runs and each wrap toggles a blink bit.
  - digitsOut alternates 16'h0000 (bit=0) and 16'hFFFF (bit=1, blanked digits).
  - The blink bit clears on entry to EXPIRED.
  - tick stays 0 in EXPIRED.
- Undefined: digitsOut is a constant 16'h0000 in EXPIRED and the prescaler is idle.

Test Plan (TICK_DIV=4):
- Reset release -> currentState=1, initialClockValue=16'h0500, paused=1, digitsOut=set_value after 1 cycle.
- SETTING with set_value=16'h0230, set_valid=1, then set_value=16'h0261, set_valid=1 -> initialClockValue stays 16'h0230 (sec1=6 rejected). Then mode event -> currentState=0, single load pulse, tick every 4th cycle starting 4 cycles after load.
- COUNTING, start event after 2 prescaler counts, wait 10 cycles, start again -> no tick while paused; first tick arrives 2 cycles after resume.
- COUNTING, finished=1 in the same cycle as mode and clear events -> currentState=2, alarm=1, digitsOut=16'h0000. Then clear event -> currentState=1, alarm=0.
- COUNTING, clear event -> load pulse, paused=1, prescaler=0, state stays 0. Then start event -> tick 4 cycles later.
- Assert reset mid-COUNTING with prescaler=3 -> outputs return to reset values asynchronously and no tick is emitted. With EXPIRED_BLINK_EN defined, in EXPIRED digitsOut toggles 0000/FFFF every 4 cycles.

Source files
------------

// File: rtl/clock_mode_sequencer.sv
// Mode controller for the countdown clock: button events, pause, reload, 1 Hz tick and display mux.
// Optional EXPIRED_BLINK_EN: in EXPIRED the display blinks between 0000 and FFFF at the tick rate.
module clock_mode_sequencer #(
  parameter int          TICK_DIV     = 50000000,
  parameter logic [15:0] DEFAULT_TIME = 16'h0500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic [15:0] set_value,
  input  logic        set_valid,
  input  logic [15:0] count_digits,
  input  logic        finished,
  output logic [2:0]  currentState,
  output logic [15:0] initialClockValue,
  output logic        load,
  output logic        tick,
  output logic        paused,
  output logic        alarm,
  output logic [15:0] digitsOut
);

  typedef enum logic [2:0] {
    ST_COUNTING = 3'd0,
    ST_SETTING  = 3'd1,
    ST_EXPIRED  = 3'd2
  } state_t;

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  state_t        state_reg;
  logic [15:0]   init_reg;
  logic [15:0]   digits_reg;
  logic [PW-1:0] pres_reg;
  logic          load_reg;
  logic          load_d_reg;
  logic          tick_reg;
  logic          paused_reg;
  logic          alarm_reg;
  logic [2:0]    sync1_reg;
  logic [2:0]    sync2_reg;
  logic [2:0]    hist_reg;
`ifdef EXPIRED_BLINK_EN
  logic          blink_reg;
`endif

  // Button bit order: [0]=clear, [1]=mode, [2]=start.
  logic [2:0] btn_raw;
  logic [2:0] btn_ev;
  logic       ev_clear;
  logic       ev_mode;
  logic       ev_start;
  logic       fin_ev;
  logic       bcd_ok;

  assign btn_raw  = {btn_start, btn_mode, btn_clear};
  assign btn_ev   = sync2_reg & ~hist_reg;
  assign ev_clear = btn_ev[0];
  assign ev_mode  = btn_ev[1];
  assign ev_start = btn_ev[2];

  // finished is ignored while the counting datapath is still absorbing a reload.
  assign fin_ev = finished && (state_reg == ST_COUNTING) && !load_reg && !load_d_reg;

  assign bcd_ok = (set_value[15:12] <= 4'd9) && (set_value[11:8] <= 4'd9) &&
                  (set_value[7:4]   <= 4'd5) && (set_value[3:0]  <= 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_SETTING;
      init_reg   <= DEFAULT_TIME;
      digits_reg <= 16'h0000;
      pres_reg   <= '0;
      load_reg   <= 1'b0;
      load_d_reg <= 1'b0;
      tick_reg   <= 1'b0;
      paused_reg <= 1'b1;
      alarm_reg  <= 1'b0;
      sync1_reg  <= 3'b000;
      sync2_reg  <= 3'b000;
      hist_reg   <= 3'b000;
`ifdef EXPIRED_BLINK_EN
      blink_reg  <= 1'b0;
`endif
    end else begin
      sync1_reg  <= btn_raw;
      sync2_reg  <= sync1_reg;
      hist_reg   <= sync2_reg;
      load_reg   <= 1'b0;
      tick_reg   <= 1'b0;
      load_d_reg <= load_reg;

      case (state_reg)
        ST_SETTING: begin
          digits_reg <= set_value;
          if (set_valid && bcd_ok)
            init_reg <= set_value;
          // A simultaneous clear outranks mode and swallows it.
          if (!ev_clear && ev_mode) begin
            state_reg  <= ST_COUNTING;
            paused_reg <= 1'b0;
            load_reg   <= 1'b1;
            pres_reg   <= '0;
          end
        end

        ST_COUNTING: begin
          digits_reg <= count_digits;
          if (fin_ev) begin
            state_reg  <= ST_EXPIRED;
            alarm_reg  <= 1'b1;
            paused_reg <= 1'b1;
            pres_reg   <= '0;
`ifdef EXPIRED_BLINK_EN
            blink_reg  <= 1'b0;
`endif
          end else if (ev_clear) begin
            load_reg   <= 1'b1;
            paused_reg <= 1'b1;
            pres_reg   <= '0;
          end else if (ev_mode) begin
            state_reg  <= ST_SETTING;
            paused_reg <= 1'b1;
            pres_reg   <= '0;
          end else if (ev_start) begin
            paused_reg <= ~paused_reg;
          end else if (!paused_reg) begin
            if (pres_reg == PRE_MAX) begin
              pres_reg <= '0;
              tick_reg <= 1'b1;
            end else begin
              pres_reg <= pres_reg + PW'(1);
            end
          end
        end

        ST_EXPIRED: begin
`ifdef EXPIRED_BLINK_EN
          digits_reg <= blink_reg ? 16'hFFFF : 16'h0000;
`else
          digits_reg <= 16'h0000;
`endif
          if (ev_clear || ev_mode) begin
            state_reg <= ST_SETTING;
            alarm_reg <= 1'b0;
            pres_reg  <= '0;
          end
`ifdef EXPIRED_BLINK_EN
          else if (pres_reg == PRE_MAX) begin
            pres_reg  <= '0;
            blink_reg <= ~blink_reg;
          end else begin
            pres_reg <= pres_reg + PW'(1);
          end
`endif
        end

        default: begin
          state_reg  <= ST_SETTING;
          paused_reg <= 1'b1;
          alarm_reg  <= 1'b0;
          pres_reg   <= '0;
        end
      endcase
    end
  end

  assign currentState      = state_reg;
  assign initialClockValue = init_reg;
  assign load              = load_reg;
  assign tick              = tick_reg;
  assign paused            = paused_reg;
  assign alarm             = alarm_reg;
  assign digitsOut         = digits_reg;

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Randomized bench for clock_mode_sequencer against a behavioural mode/timing model.
module tb_clock_mode_sequencer;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] set_value = 16'h0000;
  logic        set_valid = 1'b0;
  logic [15:0] count_digits = 16'h0000;
  logic        finished = 1'b0;
  logic [2:0]  currentState;
  logic [15:0] initialClockValue;
  logic        load;
  logic        tick;
  logic        paused;
  logic        alarm;
  logic [15:0] digitsOut;

  clock_mode_sequencer #(.TICK_DIV(TICK_DIV), .DEFAULT_TIME(16'h0500)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_start(btn_start), .btn_clear(btn_clear),
    .set_value(set_value), .set_valid(set_valid),
    .count_digits(count_digits), .finished(finished),
    .currentState(currentState), .initialClockValue(initialClockValue),
    .load(load), .tick(tick), .paused(paused), .alarm(alarm),
    .digitsOut(digitsOut)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0=COUNTING 1=SETTING 2=EXPIRED; run_cnt counts uninterrupted run cycles.
  int          m_mode;
  logic [15:0] m_init;
  logic [15:0] m_digits;
  bit          m_paused, m_alarm, m_load, m_load_prev, m_tick, m_blink;
  int          m_run_cnt;
  logic [2:0]  btn_seen [3];   // button levels sampled 1, 2, 3 edges ago

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_valid_time(input logic [15:0] v);
    int lim;
    for (int d = 0; d < 4; d++) begin
      lim = (d == 1) ? 5 : 9;
      if (int'((v >> (4 * d)) & 16'h000F) > lim) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 1; m_init = 16'h0500; m_paused = 1; m_alarm = 0;
    m_load = 0; m_load_prev = 0; m_tick = 0; m_blink = 0; m_run_cnt = 0;
    for (int k = 0; k < 3; k++) btn_seen[k] = 3'b000;
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples at that edge.
  task automatic model_step();
    logic [2:0] rose;
    bit ec, em, es, fin, nload, ntick;
    rose = btn_seen[1] & ~btn_seen[2];
    ec = rose[0]; em = rose[1]; es = rose[2];
    btn_seen[2] = btn_seen[1];
    btn_seen[1] = btn_seen[0];
    btn_seen[0] = {btn_start, btn_mode, btn_clear};
    fin = finished && (m_mode == 0) && !m_load && !m_load_prev;
    nload = 0; ntick = 0;
    m_load_prev = m_load;
    if (m_mode == 1) begin
      m_digits = set_value;
      if (set_valid && is_valid_time(set_value)) m_init = set_value;
      if (em && !ec) begin m_mode = 0; m_paused = 0; nload = 1; m_run_cnt = 0; end
    end else if (m_mode == 0) begin
      m_digits = count_digits;
      if (fin) begin m_mode = 2; m_alarm = 1; m_paused = 1; m_run_cnt = 0; m_blink = 0; end
      else if (ec) begin nload = 1; m_paused = 1; m_run_cnt = 0; end
      else if (em) begin m_mode = 1; m_paused = 1; m_run_cnt = 0; end
      else if (es) m_paused = !m_paused;
      else if (!m_paused) begin
        m_run_cnt++;
        if (m_run_cnt == TICK_DIV) begin m_run_cnt = 0; ntick = 1; end
      end
    end else begin
`ifdef EXPIRED_BLINK_EN
      m_digits = m_blink ? 16'hFFFF : 16'h0000;
`else
      m_digits = 16'h0000;
`endif
      if (ec || em) begin m_mode = 1; m_alarm = 0; m_run_cnt = 0; end
`ifdef EXPIRED_BLINK_EN
      else begin
        m_run_cnt++;
        if (m_run_cnt == TICK_DIV) begin m_run_cnt = 0; m_blink = !m_blink; end
      end
`endif
    end
    m_load = nload;
    m_tick = ntick;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_state",  32'(currentState), 32'd1);
    check_eq("rst_init",   32'(initialClockValue), 32'h0500);
    check_eq("rst_load",   32'(load), 32'd0);
    check_eq("rst_tick",   32'(tick), 32'd0);
    check_eq("rst_paused", 32'(paused), 32'd1);
    check_eq("rst_alarm",  32'(alarm), 32'd0);
  endtask

  task automatic check_outputs();
    check_eq("state",  32'(currentState), 32'(m_mode));
    check_eq("init",   32'(initialClockValue), 32'(m_init));
    check_eq("load",   32'(load), 32'(m_load));
    check_eq("tick",   32'(tick), 32'(m_tick));
    check_eq("paused", 32'(paused), 32'(m_paused));
    check_eq("alarm",  32'(alarm), 32'(m_alarm));
    check_eq("digits", 32'(digitsOut), 32'(m_digits));
  endtask

  task automatic drive_random();
    if ($urandom_range(15) == 0) btn_mode  = ~btn_mode;
    if ($urandom_range(15) == 0) btn_start = ~btn_start;
    if ($urandom_range(15) == 0) btn_clear = ~btn_clear;
    finished  = ($urandom_range(23) == 0);
    set_valid = $urandom_range(1) == 1;
    if ($urandom_range(1) == 1)
      set_value = {4'($urandom_range(9)), 4'($urandom_range(9)),
                   4'($urandom_range(5)), 4'($urandom_range(9))};
    else
      set_value = 16'($urandom());
    count_digits = 16'($urandom());
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
      if (i % 900 == 450) begin
        reset = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
